seven_seg_mux: RTL and testbench

//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits on one shared segment bus.

---
 rtl/seven_seg_pkg.sv | 20 ++
 rtl/seven_seg_decode.sv | 12 +
 rtl/seven_seg_mux.sv | 98 +++++++++
 tb/tb_seven_seg_mux.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment types and the hex glyph table (active-low base encoding).
// Pure constants; no latency, no backpressure.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Bit order: seg[0]=a ... seg[6]=g; a 0 lights the segment.
  localparam seg_t SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to seven-segment glyph, active-low base encoding.
// Combinational, zero latency; no flow control.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = SEG_PATTERN[nib];

endmodule

// File: rtl/seven_seg_mux.sv
// Round-robin scan driver for multiplexed seven-segment digits with per-slot dead time.
// Outputs registered (1 cycle); input value latched once per frame, never stalls.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 240,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_FLIP = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_FLIP  = AN_ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;

  state_t                  state;
  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              nib;
  seg_t                    glyph;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    lz_acc;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   an_sel;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign nib       = shadow[int'(idx)*4 +: 4];
  assign an_sel    = NUM_DIGITS'(1) << idx;

  always_comb begin
    state = (int'(cnt) < BLANK_CYCLES) ? ST_BLANK : ST_ON;
  end

  // lead_zero[i] is set when nibbles i..top are all zero.
  always_comb begin
    lz_acc    = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_acc       = lz_acc & (shadow[4*i +: 4] == 4'h0);
      lead_zero[i] = lz_acc;
    end
  end

  always_comb begin
    dark = (state == ST_BLANK)
        || !digit_en[idx]
        || (lz_suppress && (idx != '0) && lead_zero[idx]);
  end

  seven_seg_decode u_decode (
    .nib (nib),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= digits_i;
      seg        <= SEG_OFF ^ SEG_FLIP;
      an         <= AN_FLIP;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_end) begin
        shadow <= digits_i;
      end
      frame_tick <= frame_end;
      seg        <= (dark ? SEG_OFF : glyph) ^ SEG_FLIP;
      an         <= (dark ? '0 : an_sel) ^ AN_FLIP;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench: the driver predicts each cycle's outputs from elapsed scan time,
// a monitor compares them against the DUT one edge later.
module tb_seven_seg_mux;

  localparam int N = 2;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = N * R;

  localparam logic [6:0] PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk = 1'b1;
  logic       reset_n = 1'b0;
  logic [7:0] digits_i = 8'h00;
  logic [1:0] digit_en = 2'b11;
  logic       lz_suppress = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  always #5 clk = ~clk;

  seven_seg_mux #(
    .NUM_DIGITS     (N),
    .REFRESH_CYCLES (R),
    .BLANK_CYCLES   (B),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digits_i    (digits_i),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       ft;
  } exp_t;

  exp_t       expq[$];
  int         tests = 0;
  int         fails = 0;
  int         p = 0;
  logic [7:0] mshadow = 8'h00;

  function automatic bit upper_zero(input logic [7:0] v, input int s);
    for (int i = s; i < N; i++)
      if (v[4*i +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  // p counts edges since reset release; the display at edge p is a pure function of p.
  task automatic drive(input logic rst, input logic [7:0] d, input logic [1:0] en, input logic lz);
    exp_t       e;
    int         slot;
    int         off;
    logic [3:0] nv;
    bit         drk;
    @(negedge clk);
    reset_n     = rst;
    digits_i    = d;
    digit_en    = en;
    lz_suppress = lz;
    if (!rst) begin
      e.seg   = 7'h7F;
      e.an    = 2'b11;
      e.ft    = 1'b0;
      mshadow = d;
      p       = 0;
    end else begin
      slot  = (p / R) % N;
      off   = p % R;
      nv    = mshadow[4*slot +: 4];
      drk   = (off < B) || !en[slot] || (lz && slot != 0 && upper_zero(mshadow, slot));
      e.seg = drk ? 7'h7F : PAT[nv];
      e.an  = drk ? 2'b11 : ~(2'b01 << slot);
      e.ft  = (p % F == F - 1);
      if (p % F == F - 1) mshadow = d;
      p++;
    end
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("seg", seg, e.seg);
      chk("an", {5'b0, an}, {5'b0, e.an});
      chk("frame_tick", {6'b0, frame_tick}, {6'b0, e.ft});
    end
  end

  function automatic logic [7:0] rand_digits();
    logic [7:0] v;
    for (int i = 0; i < N; i++)
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin : stim
    logic [7:0] rd;
    logic [1:0] ren;
    logic       rlz;
    logic       rrst;

    repeat (3) drive(1'b0, 8'h3A, 2'b11, 1'b0);
    repeat (40) drive(1'b1, 8'h3A, 2'b11, 1'b0);

    // Change the input while digit 0 is lit; digit 1 must keep the old value.
    while (p % F != 4) drive(1'b1, 8'h3A, 2'b11, 1'b0);
    repeat (40) drive(1'b1, 8'h5C, 2'b11, 1'b0);

    repeat (40) drive(1'b1, 8'h05, 2'b11, 1'b1);
    repeat (40) drive(1'b1, 8'h00, 2'b11, 1'b1);
    repeat (40) drive(1'b1, 8'h3A, 2'b01, 1'b0);

    // Reset while digit 1 is lit.
    while (p % F != 12) drive(1'b1, 8'h3A, 2'b11, 1'b0);
    drive(1'b0, 8'h3A, 2'b11, 1'b0);
    repeat (40) drive(1'b1, 8'h3A, 2'b11, 1'b0);

    rd   = 8'h12;
    ren  = 2'b11;
    rlz  = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) rd = rand_digits();
      if ($urandom_range(0, 29) == 0) ren = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) rlz = ~rlz;
      rrst = ($urandom_range(0, 199) != 0);
      drive(rrst, rd, ren, rlz);
    end

    for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
